// File: rtl/block_pe_elastic_pkg.sv
// rtl/block_pe_elastic_pkg.sv - shared op codes, config view and select-width helper for the elastic PE
package block_pe_elastic_pkg;

  localparam int SEL_MAX = 8;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  // Decoded view of the serial config register; selects are zero-extended to SEL_MAX.
  typedef struct packed {
    op_e               op;
    logic [SEL_MAX-1:0] sel_b;
    logic [SEL_MAX-1:0] sel_a;
  } cfg_t;

  function automatic int sel_w(input int num_in);
    return $clog2(num_in + 1);
  endfunction

endpackage

// File: rtl/pe_sync_fifo.sv
// rtl/pe_sync_fifo.sv - synchronous output FIFO with wrap-modulo-DEPTH pointers
module pe_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/block_pe_elastic.sv
// rtl/block_pe_elastic.sv - elastic two-operand PE with serial config and output FIFO
// Optional constant operand enabled by BLOCK_PE_CONST_EN.
module block_pe_elastic
  import block_pe_elastic_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_IN = 4,
  parameter int FIFO_D = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     config_en,
  input  logic                     config_in,
  output logic                     config_out,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int SEL_W = sel_w(NUM_IN);
  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(FIFO_D + 1);
`ifdef BLOCK_PE_CONST_EN
  localparam int CFG_W = 2*SEL_W + 3 + DATA_W;
`else
  localparam int CFG_W = 2*SEL_W + 3;
`endif

  logic [CFG_W-1:0]  cfg_reg;
  cfg_t              cfg;
  logic [DATA_W-1:0] const_val;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] a_data, b_data, result, head;
  logic              a_vld, b_vld, fire;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  always_comb begin
    cfg       = '0;
    cfg.sel_a = SEL_MAX'(cfg_reg[SEL_W-1:0]);
    cfg.sel_b = SEL_MAX'(cfg_reg[2*SEL_W-1:SEL_W]);
    cfg.op    = op_e'(cfg_reg[2*SEL_W+2 -: 3]);
  end

`ifdef BLOCK_PE_CONST_EN
  assign const_val = cfg_reg[CFG_W-1 -: DATA_W];
`else
  assign const_val = '0;
`endif

  // Returns {valid, data}; accumulator, constant and out-of-range selects are always valid.
  function automatic logic [DATA_W:0] pick(
    input logic [SEL_MAX-1:0]       sel,
    input logic [NUM_IN*DATA_W-1:0] d,
    input logic [NUM_IN-1:0]        v,
    input logic [DATA_W-1:0]        acc_v,
    input logic [DATA_W-1:0]        k
  );
    logic [DATA_W:0] r;
    r = {1'b1, {DATA_W{1'b0}}};
    for (int i = 0; i < NUM_IN; i++)
      if (sel == SEL_MAX'(i)) r = {v[i], d[i*DATA_W +: DATA_W]};
    if (sel == SEL_MAX'(NUM_IN))     r = {1'b1, acc_v};
    if (sel == SEL_MAX'(NUM_IN + 1)) r = {1'b1, k};
    return r;
  endfunction

  assign {a_vld, a_data} = pick(cfg.sel_a, in_data, in_valid, acc, const_val);
  assign {b_vld, b_data} = pick(cfg.sel_b, in_data, in_valid, acc, const_val);

  assign fire = reset && !config_en && !fifo_full && a_vld && b_vld;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++)
      in_ready[i] = fire && (cfg.sel_a == SEL_MAX'(i) || cfg.sel_b == SEL_MAX'(i));
  end

  always_comb begin
    result = a_data;
    case (cfg.op)
      OP_ADD:  result = a_data + b_data;
      OP_SUB:  result = a_data - b_data;
      OP_AND:  result = a_data & b_data;
      OP_OR:   result = a_data | b_data;
      OP_XOR:  result = a_data ^ b_data;
      OP_SHL:  result = a_data << b_data[SH_W-1:0];
      OP_SHR:  result = a_data >> b_data[SH_W-1:0];
      default: result = a_data;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_reg <= '0;
      acc     <= '0;
    end else begin
      if (config_en) cfg_reg <= {cfg_reg[CFG_W-2:0], config_in};
      if (fire)      acc     <= result;
    end
  end

  pe_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_D)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fire),
    .push_data (result),
    .pop       (out_valid && out_ready),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid  = (fifo_count != '0);
  assign out_data   = fifo_empty ? '0 : head;
  assign config_out = cfg_reg[CFG_W-1];

endmodule

// File: tb/tb_block_pe_elastic.sv
// tb/tb_block_pe_elastic.sv - directed self-checking bench for block_pe_elastic
module tb_block_pe_elastic;

  localparam int DATA_W = 32;
  localparam int NUM_IN = 4;
  localparam int FIFO_D = 2;
  localparam int CFG_W  = 9;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     config_en = 1'b0;
  logic                     config_in = 1'b0;
  logic                     config_out;
  logic [NUM_IN*DATA_W-1:0] in_data = '0;
  logic [NUM_IN-1:0]        in_valid = '0;
  logic [NUM_IN-1:0]        in_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready = 1'b0;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  block_pe_elastic #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .FIFO_D(FIFO_D)) dut (
    .clk        (clk),
    .reset      (reset),
    .config_en  (config_en),
    .config_in  (config_in),
    .config_out (config_out),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  function automatic logic [CFG_W-1:0] mk(input int op, input int sb, input int sa);
    return {3'(op), 3'(sb), 3'(sa)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [CFG_W-1:0] v);
    config_en = 1'b1;
    for (int i = CFG_W - 1; i >= 0; i--) begin
      config_in = v[i];
      step();
    end
    config_en = 1'b0;
    config_in = 1'b0;
  endtask

  task automatic set_ch(input int ch, input logic [DATA_W-1:0] v);
    in_data[ch*DATA_W +: DATA_W] = v;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #3;
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    in_valid = 4'b1111;
    set_ch(0, 32'd3);
    #2;
    vectors++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rst_in_ready: got %b want 0000", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    vectors++; if (config_out !== 1'b0) begin errors++; $display("FAIL rst_config_out: got %b want 0", config_out); end
    vectors++; if (out_data !== 32'd0) begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    in_valid = '0;
    #2;
    reset = 1'b1;
    step();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rel_out_valid: got %b want 0", out_valid); end
    vectors++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rel_in_ready: got %b want 0000", in_ready); end
    vectors++; if (config_out !== 1'b0) begin errors++; $display("FAIL rel_config_out: got %b want 0", config_out); end
  endtask

  task automatic test_add();
    load_cfg(mk(0, 1, 0));
    out_ready = 1'b1;
    set_ch(0, 32'd5);
    set_ch(1, 32'd7);
    in_valid = 4'b0011;
    #1;
    vectors++; if (in_ready !== 4'b0011) begin errors++; $display("FAIL add_in_ready: got %b want 0011", in_ready); end
    step();
    in_valid = '0;
    #1;
    vectors++; if (out_valid !== 1'b1 || out_data !== 32'd12) begin errors++; $display("FAIL add_result: got v=%b d=%0d want v=1 d=12", out_valid, out_data); end
    vectors++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL add_ready_drop: got %b want 0000", in_ready); end
    step();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_popped: got %b want 0", out_valid); end
  endtask

  task automatic test_same_channel();
    load_cfg(mk(0, 0, 0));
    set_ch(0, 32'd9);
    in_valid = 4'b0001;
    #1;
    vectors++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL same_in_ready: got %b want 0001", in_ready); end
    step();
    in_valid = '0;
    #1;
    vectors++; if (out_data !== 32'd18) begin errors++; $display("FAIL same_result: got %0d want 18", out_data); end
    step();
  endtask

  task automatic test_backpressure();
    int fires;
    fires = 0;
    load_cfg(mk(0, 1, 0));
    out_ready = 1'b0;
    set_ch(1, 32'd1);
    in_valid = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      set_ch(0, 32'(10 + k));
      #1;
      if (in_ready[0]) fires++;
      step();
    end
    vectors++; if (fires !== FIFO_D) begin errors++; $display("FAIL bp_fire_count: got %0d want %0d", fires, FIFO_D); end
    vectors++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_full_ready: got %b want 0000", in_ready); end
    out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_full_pop_ready: got %b want 0000", in_ready); end
    vectors++; if (out_data !== 32'd11) begin errors++; $display("FAIL bp_first: got %0d want 11", out_data); end
    in_valid = '0;
    step();
    vectors++; if (out_valid !== 1'b1 || out_data !== 32'd12) begin errors++; $display("FAIL bp_second: got v=%b d=%0d want v=1 d=12", out_valid, out_data); end
    step();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_accumulate();
    int exp_v [3];
    exp_v = '{1, 3, 6};
    pulse_reset();
    load_cfg(mk(0, 0, NUM_IN));
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_ch(0, 32'(k + 1));
      in_valid = 4'b0001;
      step();
      vectors++; if (out_valid !== 1'b1 || out_data !== 32'(exp_v[k])) begin errors++; $display("FAIL acc_%0d: got v=%b d=%0d want v=1 d=%0d", k, out_valid, out_data, exp_v[k]); end
    end
    in_valid = '0;
    step();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL acc_drained: got %b want 0", out_valid); end
  endtask

  task automatic run_op(input string name, input logic [CFG_W-1:0] c,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
    load_cfg(c);
    out_ready = 1'b1;
    set_ch(0, a);
    set_ch(1, b);
    in_valid = 4'b0011;
    step();
    in_valid = '0;
    #1;
    vectors++; if (out_valid !== 1'b1 || out_data !== expv) begin errors++; $display("FAIL %s: got v=%b d=%h want v=1 d=%h", name, out_valid, out_data, expv); end
    step();
  endtask

  task automatic test_ops();
    pulse_reset();
    load_cfg(mk(5, 1, 0));
    vectors++; if (config_out !== 1'b1) begin errors++; $display("FAIL cfg_msb_out: got %b want 1", config_out); end
    run_op("sub_wrap",  mk(1, 1, 0), 32'h0,        32'h1,        32'hFFFF_FFFF);
    run_op("add_wrap",  mk(0, 1, 0), 32'hFFFF_FFFF, 32'h2,       32'h1);
    run_op("shl_mod",   mk(5, 1, 0), 32'h1,        32'd33,       32'h2);
    run_op("shr_logic", mk(6, 1, 0), 32'h8000_0000, 32'd31,      32'h1);
    run_op("and",       mk(2, 1, 0), 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
    run_op("or",        mk(3, 1, 0), 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF);
    run_op("xor",       mk(4, 1, 0), 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0);
    run_op("pass",      mk(7, 1, 0), 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hF0F0_00FF);
    run_op("sel_zero",  mk(0, 7, 0), 32'h55,       32'h99,       32'h55);
  endtask

  task automatic test_config_drain();
    pulse_reset();
    load_cfg(mk(0, 1, 0));
    out_ready = 1'b0;
    set_ch(0, 32'd1);
    set_ch(1, 32'd1);
    in_valid = 4'b0011;
    step();
    step();
    config_en = 1'b1;
    config_in = 1'b0;
    out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL cfg_in_ready: got %b want 0000", in_ready); end
    vectors++; if (out_valid !== 1'b1 || out_data !== 32'd2) begin errors++; $display("FAIL cfg_head: got v=%b d=%0d want v=1 d=2", out_valid, out_data); end
    step();
    step();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cfg_drained: got %b want 0", out_valid); end
    config_en = 1'b0;
    in_valid = '0;
  endtask

  task automatic test_midop_reset();
    pulse_reset();
    load_cfg(mk(0, 1, 0));
    out_ready = 1'b0;
    set_ch(0, 32'd4);
    set_ch(1, 32'd4);
    in_valid = 4'b0011;
    step();
    step();
    in_valid = '0;
    #1;
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_queued: got %b want 1", out_valid); end
    #1;
    reset = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== 32'd0) begin errors++; $display("FAIL mid_async_data: got %h want 0", out_data); end
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_after_release: got %b want 0", out_valid); end
    step();
    vectors++; if (out_valid !== 1'b0 || config_out !== 1'b0) begin errors++; $display("FAIL mid_still_empty: got v=%b c=%b want 0 0", out_valid, config_out); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_same_channel();
    test_backpressure();
    test_accumulate();
    test_ops();
    test_config_drain();
    test_midop_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
